// File: rtl/loader_pkg.sv
// Shared types and stream-format constants for the program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StData,
    StCheck,
    StDone,
    StError
  } state_t;

  localparam int unsigned HEADER_BYTES = 2;
  localparam int unsigned WORD_BYTES   = 4;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write bus of the program loader.
interface program_loader_if;
    logic        ByteValid;
    logic [7:0]  ByteData;
    logic        ByteReady;
    logic        MemWrite;
    logic [31:0] MemAddress;
    logic [31:0] MemData;

    modport master (
        output ByteValid, ByteData,
        input  ByteReady, MemWrite, MemAddress, MemData
    );

    modport slave (
        input  ByteValid, ByteData,
        output ByteReady, MemWrite, MemAddress, MemData
    );
endinterface

// File: rtl/word_assembler.sv
// Packs a big-endian byte stream into 32-bit words; pulses wordComplete with the 4th byte.
module word_assembler
    import loader_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic        clear,
    input  logic        byteStrobe,
    input  logic [7:0]  byteData,
    output logic [31:0] word,
    output logic        wordComplete
);

    logic [1:0]  byteCount;
    logic [23:0] shiftReg;

    // The incoming byte is the LSB, so the full word is visible in the completing cycle.
    assign word         = {shiftReg, byteData};
    assign wordComplete = byteStrobe && (byteCount == 2'(WORD_BYTES - 1));

    always_ff @(posedge Clock) begin
        if (!Reset || clear) begin
            byteCount <= '0;
            shiftReg  <= '0;
        end else if (byteStrobe) begin
            byteCount <= byteCount + 2'd1;
            shiftReg  <= {shiftReg[15:0], byteData};
        end
    end

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction memory
// while holding the core stalled.
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned DEPTH = 100
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    program_loader_if.slave  bus,
    output logic             CoreHold,
    output logic             Done,
    output logic             Error
);

    state_t      state;
    logic [7:0]  lenHi;
    logic [7:0]  checksum;
    logic [15:0] wordCount;
    logic [15:0] wordTotal;
    logic [15:0] lenWord;
    logic        memWrite;
    logic [31:0] memAddress;
    logic [31:0] memData;
    logic        inLoad;
    logic        byteFire;
    logic        startLoad;
    logic [31:0] word;
    logic        wordComplete;

    assign inLoad    = state inside {StLenHi, StLenLo, StData, StCheck};
    assign byteFire  = bus.ByteValid && inLoad;
    assign startLoad = Start && (state inside {StIdle, StDone, StError});
    assign lenWord   = {lenHi, bus.ByteData};

    assign bus.ByteReady  = inLoad;
    assign bus.MemWrite   = memWrite;
    assign bus.MemAddress = memAddress;
    assign bus.MemData    = memData;
    assign CoreHold       = inLoad;

    word_assembler assembler (
        .Clock        (Clock),
        .Reset        (Reset),
        .clear        (startLoad),
        .byteStrobe   (byteFire && (state == StData)),
        .byteData     (bus.ByteData),
        .word         (word),
        .wordComplete (wordComplete)
    );

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state      <= StIdle;
            lenHi      <= '0;
            checksum   <= '0;
            wordCount  <= '0;
            wordTotal  <= '0;
            memWrite   <= 1'b0;
            memAddress <= '0;
            memData    <= '0;
            Done       <= 1'b0;
            Error      <= 1'b0;
        end else begin
            memWrite <= 1'b0;
            if (startLoad) begin
                state      <= StLenHi;
                checksum   <= '0;
                wordCount  <= '0;
                wordTotal  <= '0;
                memAddress <= '0;
                Done       <= 1'b0;
                Error      <= 1'b0;
            end else if (byteFire) begin
                // The checksum byte itself is excluded from the running XOR.
                if (state != StCheck) checksum <= checksum ^ bus.ByteData;
                unique case (state)
                    StLenHi: begin
                        lenHi <= bus.ByteData;
                        state <= StLenLo;
                    end
                    StLenLo: begin
                        wordTotal <= lenWord;
                        if (lenWord == 16'd0) begin
                            state <= StCheck;
                        end else if (lenWord > 16'(DEPTH)) begin
                            state <= StError;
                            Error <= 1'b1;
                        end else begin
                            state <= StData;
                        end
                    end
                    StData: begin
                        if (wordComplete) begin
                            memWrite   <= 1'b1;
                            memData    <= word;
                            memAddress <= 32'(wordCount);
                            wordCount  <= wordCount + 16'd1;
                            if (wordCount + 16'd1 == wordTotal) state <= StCheck;
                        end
                    end
                    StCheck: begin
                        if (bus.ByteData == checksum) begin
                            state <= StDone;
                            Done  <= 1'b1;
                        end else begin
                            state <= StError;
                            Error <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed, table-driven bench for program_loader: stream vectors plus reset/mid-load sequences.
module tb_program_loader;
    import loader_pkg::*;

    typedef struct {
        logic [15:0]      n;
        int               nData;
        logic [3:0][31:0] w;
        logic [7:0]       ck;
        bit               sendCk;
        bit               gap;
        bit               midStart;
        bit               expDone;
        bit               expError;
        int               expWrites;
    } vec_t;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    logic Start = 1'b0;
    logic CoreHold, Done, Error;

    program_loader_if bus ();

    program_loader #(.DEPTH(100)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Start    (Start),
        .bus      (bus),
        .CoreHold (CoreHold),
        .Done     (Done),
        .Error    (Error)
    );

    always #5 Clock = ~Clock;

    int passed = 0;
    int total  = 0;

    int          wrCount = 0;
    int          dblWr   = 0;
    logic        prevWr  = 1'b0;
    logic [31:0] wAddr[8];
    logic [31:0] wData[8];

    always @(negedge Clock) begin
        if (bus.MemWrite === 1'b1) begin
            if (prevWr) dblWr = dblWr + 1;
            if (wrCount < 8) begin
                wAddr[wrCount] = bus.MemAddress;
                wData[wrCount] = bus.MemData;
            end
            wrCount = wrCount + 1;
        end
        prevWr = bus.MemWrite;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Present one byte until accepted; optionally check the MemWrite pulse right after.
    task automatic sendByte(input logic [7:0] b, input bit gap, input bit chkWr, input bit expWr);
        int t = 0;
        bus.ByteValid = 1'b1;
        bus.ByteData  = b;
        while (!bus.ByteReady && t < 20) begin
            @(posedge Clock); #1;
            t++;
        end
        if (t >= 20) check("byte_ready_timeout", 32'(bus.ByteReady), 32'd1);
        @(posedge Clock); #1;
        bus.ByteValid = 1'b0;
        if (chkWr) check("memwrite_pulse", 32'(bus.MemWrite), 32'(expWr));
        if (gap) begin
            @(posedge Clock); #1;
        end
    endtask

    task automatic runLoad(input vec_t v);
        logic [31:0] cw;
        wrCount = 0;
        dblWr   = 0;
        Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        check("ready_after_start", 32'(bus.ByteReady), 32'd1);
        check("done_cleared", 32'(Done), 32'd0);
        check("error_cleared", 32'(Error), 32'd0);
        sendByte(v.n[15:8], v.gap, 1'b0, 1'b0);
        sendByte(v.n[7:0], v.gap && (v.nData > 0 || v.sendCk), 1'b0, 1'b0);
        for (int j = 0; j < v.nData * 4; j++) begin
            if (v.midStart && j == 5) begin
                Start = 1'b1;
                @(posedge Clock); #1;
                Start = 1'b0;
                check("start_ignored_hold", 32'(CoreHold), 32'd1);
            end
            cw = v.w[j / 4];
            sendByte(cw[31 - 8 * (j % 4) -: 8], v.gap, 1'b1, (j % 4) == 3);
        end
        if (v.sendCk) sendByte(v.ck, 1'b0, 1'b0, 1'b0);
        check("done", 32'(Done), 32'(v.expDone));
        check("error", 32'(Error), 32'(v.expError));
        check("corehold_end", 32'(CoreHold), 32'd0);
        check("ready_end", 32'(bus.ByteReady), 32'd0);
        @(posedge Clock); #1;
        check("write_count", 32'(wrCount), 32'(v.expWrites));
        check("no_back_to_back_write", 32'(dblWr), 32'd0);
        for (int i = 0; i < v.expWrites && i < 4; i++) begin
            check("write_addr", wAddr[i], 32'(i));
            check("write_data", wData[i], v.w[i]);
        end
        check("done_held", 32'(Done), 32'(v.expDone));
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, "_ready"}, 32'(bus.ByteReady), 32'd0);
        check({tag, "_memwrite"}, 32'(bus.MemWrite), 32'd0);
        check({tag, "_corehold"}, 32'(CoreHold), 32'd0);
        check({tag, "_done"}, 32'(Done), 32'd0);
        check({tag, "_error"}, 32'(Error), 32'd0);
        check({tag, "_addr"}, bus.MemAddress, 32'd0);
        check({tag, "_data"}, bus.MemData, 32'd0);
    endtask

    vec_t vecs[5];
    vec_t v4;

    initial begin
        bus.ByteValid = 1'b0;
        bus.ByteData  = 8'h00;

        // Checksums by hand: XOR of length bytes and all data bytes.
        vecs[0] = '{n: 16'd2, nData: 2, w: {32'h0, 32'h0, 32'h38000002, 32'h1BE00000},
                    ck: 8'hC3, sendCk: 1, gap: 0, midStart: 0,
                    expDone: 1, expError: 0, expWrites: 2};
        vecs[1] = '{n: 16'd0, nData: 0, w: '0, ck: 8'h00, sendCk: 1, gap: 0, midStart: 0,
                    expDone: 1, expError: 0, expWrites: 0};
        vecs[2] = '{n: 16'd101, nData: 0, w: '0, ck: 8'h00, sendCk: 0, gap: 0, midStart: 0,
                    expDone: 0, expError: 1, expWrites: 0};
        vecs[3] = '{n: 16'd1, nData: 1, w: {32'h0, 32'h0, 32'h0, 32'hDEADBEEF},
                    ck: 8'h24, sendCk: 1, gap: 0, midStart: 0,
                    expDone: 0, expError: 1, expWrites: 1};
        vecs[4] = '{n: 16'd3, nData: 3,
                    w: {32'h0, 32'h33333333, 32'h22222222, 32'h11111111},
                    ck: 8'h03, sendCk: 1, gap: 1, midStart: 1,
                    expDone: 1, expError: 0, expWrites: 3};
        v4 = '{n: 16'd4, nData: 4,
               w: {32'h00000004, 32'h00000003, 32'h00000002, 32'h00000001},
               ck: 8'h00, sendCk: 1, gap: 0, midStart: 0,
               expDone: 1, expError: 0, expWrites: 4};

        repeat (3) @(posedge Clock);
        #1;
        checkResetOutputs("reset");
        Reset = 1'b1;
        @(posedge Clock); #1;
        checkResetOutputs("idle");

        for (int k = 0; k < 5; k++) runLoad(vecs[k]);

        // Abort N=4 after six data bytes, then reload from scratch.
        Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        sendByte(8'h00, 1'b0, 1'b0, 1'b0);
        sendByte(8'h04, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 6; j++) sendByte(8'hA0 + 8'(j), 1'b0, 1'b0, 1'b0);
        check("mid_load_hold", 32'(CoreHold), 32'd1);
        Reset = 1'b0;
        @(posedge Clock); #1;
        checkResetOutputs("midreset");
        Reset = 1'b1;
        @(posedge Clock); #1;
        runLoad(v4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
